// File: rtl/mux4_rr_sel.sv
// Purpose : four-lane round-robin arbiter feeding a registered 4:1 selector that drives Z plus the SL1/SL0 select pair.
// Latency : 1 cycle from V[i] to ZV; 1 beat per cycle while ZR=1, and a new beat can load in the same cycle the held beat is consumed.
// Backpr. : ZR=0 with ZV=1 holds Z/SL/ZV and forces RDY=0; ZR reaches RDY combinationally.
//
// Ports:
//   CP        clock, rising edge
//   RST       synchronous active-high reset; it overrides every other event
//   V[3:0]    per-lane valid; A0..A3 carry the lane data (WIDTH bits each)
//   RDY[3:0]  per-lane accept; one-hot or zero; combinational from V, ZV, ZR and the internal state
//   Z, ZV     registered selected data and its valid flag
//   ZR        downstream ready
//   SL1, SL0  registered index of the lane whose beat is held in Z
//   LAST, ZL  present only when MUX4_RR_SEL_LOCK_EN is defined. LAST[i] marks the final beat
//             of a lane-i burst. ZL is the registered LAST of the held beat.
//
// Build option MUX4_RR_SEL_LOCK_EN: once a lane wins with LAST=0, the arbiter stays locked
// on that lane until the lane delivers a LAST=1 beat. The round-robin pointer moves only on LAST=1 grants.
module mux4_rr_sel #(
    parameter int WIDTH = 1
) (
    input  logic             CP,
    input  logic             RST,
    input  logic [3:0]       V,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] A3,
    output logic [3:0]       RDY,
    output logic [WIDTH-1:0] Z,
    output logic             ZV,
    input  logic             ZR,
`ifdef MUX4_RR_SEL_LOCK_EN
    input  logic [3:0]       LAST,
    output logic             ZL,
`endif
    output logic             SL0,
    output logic             SL1
);

    logic [WIDTH-1:0] z_q;
    logic             zv_q;
    logic [1:0]       sl_q;
    logic [1:0]       ptr_q;

    logic             ld;
    logic [3:0]       elig;
    logic             found;
    logic [1:0]       win;
    logic [WIDTH-1:0] a_sel;

`ifdef MUX4_RR_SEL_LOCK_EN
    logic             lock_vld_q;
    logic [1:0]       lock_lane_q;
    logic             zl_q;
`endif

    // The output register can take a new beat when it is empty or is being drained this cycle.
    assign ld = ~zv_q | ZR;

`ifdef MUX4_RR_SEL_LOCK_EN
    // While locked, only the locked lane can win. An idle locked lane therefore blocks everyone else.
    assign elig = lock_vld_q ? (V & (4'b0001 << lock_lane_q)) : V;
`else
    assign elig = V;
`endif

    // Rotating priority search: start at ptr and take the first eligible lane.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        a_sel = A0;
        case (win)
            2'd0:    a_sel = A0;
            2'd1:    a_sel = A1;
            2'd2:    a_sel = A2;
            default: a_sel = A3;
        endcase
    end

    // RDY is gated by RST, so no beat is accepted during a reset cycle.
    assign RDY = (found && ld && !RST) ? (4'b0001 << win) : 4'b0000;

    always_ff @(posedge CP) begin
        if (RST) begin
            z_q   <= '0;
            zv_q  <= 1'b0;
            sl_q  <= 2'd0;
            ptr_q <= 2'd0;
`ifdef MUX4_RR_SEL_LOCK_EN
            lock_vld_q  <= 1'b0;
            lock_lane_q <= 2'd0;
            zl_q        <= 1'b0;
`endif
        end else if (ld) begin
            if (found) begin
                z_q  <= a_sel;
                zv_q <= 1'b1;
                sl_q <= win;
`ifdef MUX4_RR_SEL_LOCK_EN
                zl_q <= LAST[win];
                if (LAST[win]) begin
                    lock_vld_q <= 1'b0;
                    ptr_q      <= win + 2'd1;
                end else begin
                    lock_vld_q  <= 1'b1;
                    lock_lane_q <= win;
                end
`else
                ptr_q <= win + 2'd1;
`endif
            end else begin
                // Drained with nothing to replace it: drop valid. Data, select and pointer keep their values.
                zv_q <= 1'b0;
            end
        end
    end

    assign Z   = z_q;
    assign ZV  = zv_q;
    assign SL0 = sl_q[0];
    assign SL1 = sl_q[1];
`ifdef MUX4_RR_SEL_LOCK_EN
    assign ZL  = zl_q;
`endif

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Purpose : directed self-checking bench for mux4_rr_sel (WIDTH=4, with a distinct data value per lane).
// Latency : outputs are sampled 1 time unit after the rising CP edge, and inputs are driven at that point too.
// Backpr. : ZR is driven from the stimulus sequence. It covers held-output and drain cases.
module tb_mux4_rr_sel;

    localparam int W = 4;

    logic         CP = 1'b0;
    logic         RST;
    logic [3:0]   V;
    logic [W-1:0] A0, A1, A2, A3;
    logic [3:0]   RDY;
    logic [W-1:0] Z;
    logic         ZV;
    logic         ZR;
    logic         SL0, SL1;
`ifdef MUX4_RR_SEL_LOCK_EN
    logic [3:0]   LAST;
    logic         ZL;
`endif

    int nerr = 0;
    int nchk = 0;

    logic [W-1:0] lane_dat [4];

    mux4_rr_sel #(.WIDTH(W)) dut (
        .CP  (CP),
        .RST (RST),
        .V   (V),
        .A0  (A0),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .RDY (RDY),
        .Z   (Z),
        .ZV  (ZV),
        .ZR  (ZR),
`ifdef MUX4_RR_SEL_LOCK_EN
        .LAST(LAST),
        .ZL  (ZL),
`endif
        .SL0 (SL0),
        .SL1 (SL1)
    );

    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    // Checks the registered outputs: valid flag, select pair, and held data.
    task automatic chk_out(input string tag, input logic ev, input logic [1:0] esl, input logic [W-1:0] ez);
        chk({tag, ".zv"}, 32'(ZV), 32'(ev));
        chk({tag, ".sl"}, 32'({SL1, SL0}), 32'(esl));
        chk({tag, ".z"},  32'(Z), 32'(ez));
    endtask

    initial begin
        lane_dat[0] = 4'h3;
        lane_dat[1] = 4'h5;
        lane_dat[2] = 4'h9;
        lane_dat[3] = 4'hC;
        A0 = lane_dat[0]; A1 = lane_dat[1]; A2 = lane_dat[2]; A3 = lane_dat[3];
        RST = 1'b1; V = 4'b1111; ZR = 1'b0;
`ifdef MUX4_RR_SEL_LOCK_EN
        LAST = 4'b1111;
`endif

        // Reset held for two edges while every lane is requesting.
        tick(); tick();
        chk_out("rst", 1'b0, 2'd0, 4'h0);
        chk("rst.rdy", 32'(RDY), 32'b0000);
        RST = 1'b0; #1;
        chk("rel.rdy", 32'(RDY), 32'b0001);
        ZR = 1'b1;

        // Fairness with every lane requesting: lanes are granted 0,1,2,3,0,1, one beat per cycle.
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out("fair", 1'b1, 2'(k % 4), lane_dat[k % 4]);
            chk("fair.rdy", 32'(RDY), 32'(4'b0001 << ((k + 1) % 4)));
        end

        // Backpressure. Lane 2 is held while ZR=0; then lane 3 follows once ZR returns.
        tick();
        chk_out("bp.load", 1'b1, 2'd2, lane_dat[2]);
        ZR = 1'b0; #1;
        chk("bp.rdy0", 32'(RDY), 32'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("bp.hold", 1'b1, 2'd2, lane_dat[2]);
            chk("bp.rdy", 32'(RDY), 32'b0000);
        end
        ZR = 1'b1; #1;
        chk("bp.rdy3", 32'(RDY), 32'b1000);
        tick();
        chk_out("bp.go", 1'b1, 2'd3, lane_dat[3]);

        // Sparse lanes and pointer wrap. A lane-2 grant sets ptr to 3; lane 1 wins next, which leaves ptr at 2.
        V = 4'b0100;
        tick();
        chk_out("sp.l2", 1'b1, 2'd2, lane_dat[2]);
        V = 4'b0010; #1;
        chk("sp.rdy1", 32'(RDY), 32'b0010);
        tick();
        chk_out("sp.l1", 1'b1, 2'd1, lane_dat[1]);
        V = 4'b0000; #1;
        chk("sp.rdy0", 32'(RDY), 32'b0000);
        tick();
        chk_out("sp.drain", 1'b0, 2'd1, lane_dat[1]);
        V = 4'b1111; #1;
        chk("sp.ptr2", 32'(RDY), 32'b0100);

        // Mid-stream reset while the held beat is from lane 3.
        V = 4'b1000;
        tick();
        chk_out("mr.l3", 1'b1, 2'd3, lane_dat[3]);
        RST = 1'b1; ZR = 1'b0; V = 4'b1111; #1;
        chk("mr.rdy", 32'(RDY), 32'b0000);
        tick();
        chk_out("mr.rst", 1'b0, 2'd0, 4'h0);
        RST = 1'b0; ZR = 1'b1; V = 4'b1001; #1;
        chk("mr.rdy0", 32'(RDY), 32'b0001);
        tick();
        chk_out("mr.l0", 1'b1, 2'd0, lane_dat[0]);

        // Reset while ptr=1. After release, lane 0 must win again.
        RST = 1'b1; V = 4'b1111;
        tick();
        chk_out("r2.rst", 1'b0, 2'd0, 4'h0);
        RST = 1'b0; #1;
        chk("r2.ptr0", 32'(RDY), 32'b0001);

`ifdef MUX4_RR_SEL_LOCK_EN
        // Lane 0 burst of LAST=0,0,1. An idle locked lane blocks the other lanes.
        LAST = 4'b1110;
        tick();
        chk_out("lk.b1", 1'b1, 2'd0, lane_dat[0]);
        chk("lk.zl1", 32'(ZL), 32'd0);
        V = 4'b1110; #1;
        chk("lk.block", 32'(RDY), 32'b0000);
        tick();
        chk("lk.gap", 32'(ZV), 32'd0);
        V = 4'b1111;
        tick();
        chk_out("lk.b2", 1'b1, 2'd0, lane_dat[0]);
        chk("lk.zl2", 32'(ZL), 32'd0);
        LAST = 4'b1111;
        tick();
        chk_out("lk.b3", 1'b1, 2'd0, lane_dat[0]);
        chk("lk.zl3", 32'(ZL), 32'd1);
        tick();
        chk_out("lk.next", 1'b1, 2'd1, lane_dat[1]);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
